if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction fetch stage of the phase-1 RISC-V core. Sits directly upstream of the if_id register and the id decoder.
- Owns the PC, issues word fetches to instruction memory over a valid/ready request channel with in-order responses, and buffers returned words in a small FIFO.
- Presents {inst, inst_addr, valid} downstream. Supports jump redirect (flushes all fetches already in flight) and downstream hold.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, max outstanding requests plus buffered instructions (power of 2, >=2).
- NOP_INST, 32'h0000_0013, instruction driven when no valid instruction is available (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- jump_en_i  input  1  redirect request from execute.
- jump_addr_i  input  32  redirect target.
- hold_i  input  1  downstream stall; head instruction is not consumed while high.
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts the request.
- imem_addr_o  output  32  fetch address (word-aligned).
- imem_rsp_valid_i  input  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data_i  input  32  fetched instruction word.
- inst_o  output  32  instruction to if_id.
- inst_addr_o  output  32  address of inst_o.
- inst_valid_o  output  1  inst_o/inst_addr_o are a real fetched instruction.

Behaviour:
- State: pc (32), inflight counter (0..DEPTH), discard counter (0..DEPTH), address FIFO (DEPTH entries, addresses of in-flight requests), output FIFO (DEPTH entries, {addr, inst}), buf_count.
- Reset (rst=1 at an edge): pc<=RESET_PC, inflight=discard=buf_count=0, both FIFOs empty.
- Outputs while rst is asserted and after reset: imem_req_valid_o=0, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0.
- Request: imem_req_valid_o = !rst && !jump_en_i && (inflight + buf_count < DEPTH); imem_addr_o = pc.
  - On a request handshake: pc <= pc+4 (wraps mod 2^32), pc pushed to the address FIFO, inflight++.
  - imem_addr_o stays stable while valid && !ready.
- Response:
  - If discard>0: the response is dropped, discard--, inflight--, address FIFO popped.
  - Otherwise: {addr FIFO head, imem_rsp_data_i} is pushed into the output FIFO, inflight--, buf_count++.
  - Credits guarantee the output FIFO never overflows. A response with inflight==0 is a protocol error and is ignored.
- Output: head of the output FIFO, registered.
  - Latency: request accepted at cycle N, response at N+k, inst_valid_o=1 at N+k+1.
  - Empty FIFO: inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0.
  - Consume when inst_valid_o && !hold_i && !jump_en_i; buf_count--.
  - With one free credit, a consume and a new request may occur in the same cycle.
- Jump (jump_en_i=1), takes priority over everything else:
  - No request is issued and no consume occurs in that cycle.
  - Output FIFO is cleared (buf_count<=0).
  - pc <= {jump_addr_i[31:2],2'b00}.
  - Any response arriving in the jump cycle is dropped.
  - discard <= inflight - imem_rsp_valid_i; inflight is updated the same way.
  - The first fetch of the target is issued the next cycle, provided no credit limit applies.
- Back-to-back jumps: each reloads pc; discard is recomputed from inflight each time.
- Reset mid-operation clears all state. Responses to pre-reset requests are outside this block's contract (memory is reset too).
- hold_i has no effect on request issue beyond credit exhaustion.

Test Plan:
- Reset, memory ready=1, 1-cycle response latency, hold=0 -> addresses 0x0,0x4,0x8 issued on consecutive cycles. inst_valid_o rises 2 cycles after the first request; inst_addr_o sequence 0x0,0x4,0x8 with matching data, one per cycle.
- hold_i=1 for 5 cycles after the first instruction -> at most DEPTH=2 requests outstanding or buffered; imem_req_valid_o=0 while full. inst_o held at the 0x0 word. Release resumes with 0x4 and no duplicates or gaps.
- imem_req_ready_i=0 for 3 cycles -> imem_req_valid_o=1 with imem_addr_o stable at 0x0. pc advances only after ready.
- Jump to 0x103 while 2 requests are in flight, 3-cycle latency -> both stale responses dropped. Next request address is 0x100; next valid inst_addr_o is 0x100.
- Jump asserted in the same cycle a response arrives and the head is valid -> that response is dropped, the head is not consumed, inst_valid_o=0 next cycle, discard=inflight-1.
- Start at RESET_PC=32'hFFFF_FFFC -> fetch 0xFFFFFFFC, then 0x00000000 (wrap).

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory channel between the fetch stage (master) and imem (slave):
// valid/ready request carrying a word address, in-order response without backpressure.
interface if_stage_if;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;

  modport master (
    output imem_req_valid_o,
    output imem_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i
  );

  modport slave (
    input  imem_req_valid_o,
    input  imem_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i,
    output imem_rsp_data_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches, buffers
// in-order responses and presents the oldest one downstream; jumps flush in-flight fetches.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  if_stage_if.master  imem,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_buf_count;

  logic [AW-1:0] r_aw_ptr;
  logic [AW-1:0] r_ar_ptr;
  logic [31:0]   r_afifo [DEPTH];

  logic [AW-1:0] r_ow_ptr;
  logic [AW-1:0] r_or_ptr;
  logic [31:0]   r_oaddr [DEPTH];
  logic [31:0]   r_oinst [DEPTH];

  logic [CW:0]   w_occupancy;
  logic          w_credit_ok;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp_take;
  logic          w_rsp_drop;
  logic          w_rsp_keep;
  logic          w_out_valid;
  logic          w_consume;
  logic [31:0]   w_jump_pc;
  logic          w_unused_jump_lsb;

  // A credit covers a slot from request acceptance until the word leaves the output buffer.
  assign w_occupancy = {1'b0, r_inflight} + {1'b0, r_buf_count};
  assign w_credit_ok = (w_occupancy < DEPTH_C);

  assign w_req_valid = !rst && !jump_en_i && w_credit_ok;
  assign w_req_fire  = w_req_valid && imem.imem_req_ready_i;

  // Responses with nothing outstanding are protocol errors and are ignored.
  assign w_rsp_take = !rst && imem.imem_rsp_valid_i && (r_inflight != '0);
  assign w_rsp_drop = w_rsp_take && (jump_en_i || (r_discard != '0));
  assign w_rsp_keep = w_rsp_take && !w_rsp_drop;

  assign w_out_valid = !rst && (r_buf_count != '0);
  assign w_consume   = w_out_valid && !hold_i && !jump_en_i;

  assign w_jump_pc         = {jump_addr_i[31:2], 2'b00};
  assign w_unused_jump_lsb = ^jump_addr_i[1:0];

  assign imem.imem_req_valid_o = w_req_valid;
  assign imem.imem_addr_o      = r_pc;

  assign inst_valid_o = w_out_valid;
  assign inst_o       = w_out_valid ? r_oinst[r_or_ptr] : NOP_INST;
  assign inst_addr_o  = w_out_valid ? r_oaddr[r_or_ptr] : 32'h0000_0000;

  // PC, outstanding-request bookkeeping and the stale-response discard count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_aw_ptr   <= '0;
      r_ar_ptr   <= '0;
    end else begin
      if (jump_en_i) begin
        r_pc <= w_jump_pc;
      end else if (w_req_fire) begin
        r_pc <= r_pc + 32'd4;
      end

      if (w_req_fire) begin
        r_aw_ptr <= r_aw_ptr + AW'(1);
      end
      if (w_rsp_take) begin
        r_ar_ptr <= r_ar_ptr + AW'(1);
      end

      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_take);

      if (jump_en_i) begin
        r_discard <= r_inflight - CW'(w_rsp_take);
      end else if (w_rsp_drop) begin
        r_discard <= r_discard - CW'(1);
      end
    end
  end

  // Output buffer control; a jump empties it in the same edge.
  always_ff @(posedge clk) begin
    if (rst || jump_en_i) begin
      r_ow_ptr    <= '0;
      r_or_ptr    <= '0;
      r_buf_count <= '0;
    end else begin
      if (w_rsp_keep) begin
        r_ow_ptr <= r_ow_ptr + AW'(1);
      end
      if (w_consume) begin
        r_or_ptr <= r_or_ptr + AW'(1);
      end
      r_buf_count <= r_buf_count + CW'(w_rsp_keep) - CW'(w_consume);
    end
  end

  // Data storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_afifo[r_aw_ptr] <= r_pc;
    end
    if (w_rsp_keep) begin
      r_oaddr[r_ow_ptr] <= r_afifo[r_ar_ptr];
      r_oinst[r_ow_ptr] <= imem.imem_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order, fixed-latency instruction memory model.
module tb_if_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic [31:0] wr_inst;
  logic [31:0] wr_inst_addr;
  logic        wr_inst_valid;

  if_stage_if imem_if ();
  if_stage_if wrap_if ();

  if_stage u_dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .hold_i       (hold),
    .imem         (imem_if),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (1'b0),
    .jump_addr_i  (32'h0000_0000),
    .hold_i       (1'b0),
    .imem         (wrap_if),
    .inst_o       (wr_inst),
    .inst_addr_o  (wr_inst_addr),
    .inst_valid_o (wr_inst_valid)
  );

  int total = 0;
  int bad   = 0;

  // Memory model: word at address A reads as A ^ 32'hDEAD_0000.
  int          lat = 1;
  int          ec  = 0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q_addr.delete();
        q_due.delete();
      end else if (imem_if.imem_req_valid_o && imem_if.imem_req_ready_i) begin
        q_addr.push_back(imem_if.imem_addr_o);
        q_due.push_back(ec + lat);
      end
      ec = ec + 1;
    end
  end

  initial begin
    imem_if.imem_rsp_valid_i = 1'b0;
    imem_if.imem_rsp_data_i  = 32'h0;
    forever begin
      @(negedge clk);
      if (q_addr.size() > 0 && q_due[0] <= ec) begin
        imem_if.imem_rsp_valid_i = 1'b1;
        imem_if.imem_rsp_data_i  = q_addr[0] ^ 32'hDEAD_0000;
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem_if.imem_rsp_valid_i = 1'b0;
        imem_if.imem_rsp_data_i  = 32'h0;
      end
    end
  end

  initial begin
    wrap_if.imem_req_ready_i = 1'b1;
    wrap_if.imem_rsp_valid_i = 1'b0;
    wrap_if.imem_rsp_data_i  = 32'h0;
  end

  // Ends at a falling edge with rst just released; the caller then drives cycle 0 inputs.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; jump_en = 1'b0; jump_addr = 32'h0; hold = 1'b0;
    imem_if.imem_req_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; jump_en = 1'b0; jump_addr = 32'h0; hold = 1'b0;
    imem_if.imem_req_ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++; if (imem_if.imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL reset_req_valid c=%0d: got %b expected 0", c, imem_if.imem_req_valid_o); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid c=%0d: got %b expected 0", c, inst_valid); end
      total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL reset_inst c=%0d: got %h expected 00000013", c, inst); end
      total++; if (inst_addr !== 32'h0) begin bad++; $display("FAIL reset_inst_addr c=%0d: got %h expected 00000000", c, inst_addr); end
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] req_a [$];
    int          req_c [$];
    logic [31:0] out_a [$];
    logic [31:0] out_d [$];
    int          first_v = -1;
    lat = 1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (imem_if.imem_req_valid_o && imem_if.imem_req_ready_i) begin
        req_a.push_back(imem_if.imem_addr_o);
        req_c.push_back(c);
      end
      if (inst_valid) begin
        if (first_v < 0) first_v = c;
        out_a.push_back(inst_addr);
        out_d.push_back(inst);
      end
    end
    total++; if (first_v !== 2) begin bad++; $display("FAIL stream_first_valid_cycle: got %0d expected 2", first_v); end
    total++;
    if (req_a.size() < 3 || out_a.size() < 3) begin
      bad++; $display("FAIL stream_counts: got req=%0d out=%0d expected >=3 each", req_a.size(), out_a.size());
    end else begin
      total++; if (req_a[0] !== 32'h0 || req_a[1] !== 32'h4 || req_a[2] !== 32'h8) begin bad++; $display("FAIL stream_req_addrs: got %h %h %h expected 0 4 8", req_a[0], req_a[1], req_a[2]); end
      total++; if (req_c[0] !== 0 || req_c[1] !== 1) begin bad++; $display("FAIL stream_req_cycles: got %0d %0d expected 0 1", req_c[0], req_c[1]); end
      total++; if (out_a[0] !== 32'h0 || out_a[1] !== 32'h4 || out_a[2] !== 32'h8) begin bad++; $display("FAIL stream_out_addrs: got %h %h %h expected 0 4 8", out_a[0], out_a[1], out_a[2]); end
      total++; if (out_d[0] !== 32'hDEAD_0000 || out_d[1] !== 32'hDEAD_0004 || out_d[2] !== 32'hDEAD_0008) begin bad++; $display("FAIL stream_out_data: got %h %h %h expected dead0000 dead0004 dead0008", out_d[0], out_d[1], out_d[2]); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] cons_a [$];
    logic [31:0] cons_d [$];
    int          held_reqs = 0;
    lat = 1;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) hold = 1'b1;
      if (c == 8) hold = 1'b0;
      #1;
      if (c <= 7 && imem_if.imem_req_valid_o && imem_if.imem_req_ready_i) held_reqs++;
      if (c >= 3 && c <= 7) begin
        total++; if (imem_if.imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL hold_req_blocked c=%0d: got %b expected 0", c, imem_if.imem_req_valid_o); end
        total++; if (inst_valid !== 1'b1 || inst_addr !== 32'h0 || inst !== 32'hDEAD_0000) begin bad++; $display("FAIL hold_head c=%0d: got v=%b a=%h d=%h expected v=1 a=0 d=dead0000", c, inst_valid, inst_addr, inst); end
      end
      if (inst_valid && !hold) begin
        cons_a.push_back(inst_addr);
        cons_d.push_back(inst);
      end
    end
    total++; if (held_reqs !== 2) begin bad++; $display("FAIL hold_req_count: got %0d expected 2", held_reqs); end
    total++;
    if (cons_a.size() < 3) begin
      bad++; $display("FAIL hold_consumed_count: got %0d expected >=3", cons_a.size());
    end else begin
      total++; if (cons_a[0] !== 32'h0 || cons_a[1] !== 32'h4 || cons_a[2] !== 32'h8) begin bad++; $display("FAIL hold_consumed_addrs: got %h %h %h expected 0 4 8", cons_a[0], cons_a[1], cons_a[2]); end
      total++; if (cons_d[1] !== 32'hDEAD_0004 || cons_d[2] !== 32'hDEAD_0008) begin bad++; $display("FAIL hold_consumed_data: got %h %h expected dead0004 dead0008", cons_d[1], cons_d[2]); end
    end
  endtask

  task automatic test_ready_stall();
    lat = 1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      imem_if.imem_req_ready_i = (c >= 3);
      #1;
      if (c <= 3) begin
        total++; if (imem_if.imem_req_valid_o !== 1'b1 || imem_if.imem_addr_o !== 32'h0) begin bad++; $display("FAIL ready_stall_stable c=%0d: got v=%b a=%h expected v=1 a=0", c, imem_if.imem_req_valid_o, imem_if.imem_addr_o); end
      end
      if (c == 4) begin
        total++; if (imem_if.imem_addr_o !== 32'h4) begin bad++; $display("FAIL ready_stall_advance: got %h expected 00000004", imem_if.imem_addr_o); end
      end
    end
  endtask

  task automatic test_jump_inflight();
    int          first_v = -1;
    logic [31:0] fa = 32'h0;
    logic [31:0] fd = 32'h0;
    lat = 3;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      jump_en = (c == 2);
      jump_addr = 32'h0000_0103;
      #1;
      if (c == 2 || c == 3) begin
        total++; if (imem_if.imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL jump_req_blocked c=%0d: got %b expected 0", c, imem_if.imem_req_valid_o); end
      end
      if (c == 4) begin
        total++; if (imem_if.imem_req_valid_o !== 1'b1 || imem_if.imem_addr_o !== 32'h100) begin bad++; $display("FAIL jump_target_req: got v=%b a=%h expected v=1 a=00000100", imem_if.imem_req_valid_o, imem_if.imem_addr_o); end
      end
      if (inst_valid && first_v < 0) begin first_v = c; fa = inst_addr; fd = inst; end
    end
    jump_en = 1'b0;
    total++; if (first_v !== 8 || fa !== 32'h100 || fd !== 32'hDEAD_0100) begin bad++; $display("FAIL jump_first_valid: got c=%0d a=%h d=%h expected c=8 a=00000100 d=dead0100", first_v, fa, fd); end
  endtask

  task automatic test_jump_collide();
    int          first_v = -1;
    logic [31:0] fa = 32'h0;
    lat = 1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      jump_en = (c == 2);
      jump_addr = 32'h0000_0200;
      #1;
      if (c == 2) begin
        total++; if (inst_valid !== 1'b1 || inst_addr !== 32'h0) begin bad++; $display("FAIL collide_head_before: got v=%b a=%h expected v=1 a=0", inst_valid, inst_addr); end
      end
      if (c == 3) begin
        total++; if (inst_valid !== 1'b0 || inst !== 32'h0000_0013 || inst_addr !== 32'h0) begin bad++; $display("FAIL collide_flushed: got v=%b d=%h a=%h expected v=0 d=00000013 a=0", inst_valid, inst, inst_addr); end
        total++; if (imem_if.imem_req_valid_o !== 1'b1 || imem_if.imem_addr_o !== 32'h200) begin bad++; $display("FAIL collide_next_req: got v=%b a=%h expected v=1 a=00000200", imem_if.imem_req_valid_o, imem_if.imem_addr_o); end
      end
      if (c >= 3 && inst_valid && first_v < 0) begin first_v = c; fa = inst_addr; end
    end
    jump_en = 1'b0;
    total++; if (first_v !== 5 || fa !== 32'h200) begin bad++; $display("FAIL collide_first_valid: got c=%0d a=%h expected c=5 a=00000200", first_v, fa); end
  endtask

  task automatic test_back_to_back();
    int          first_v = -1;
    logic [31:0] fa = 32'h0;
    logic [31:0] fd = 32'h0;
    lat = 3;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      jump_en = (c == 2 || c == 3);
      jump_addr = (c == 2) ? 32'h0000_0300 : 32'h0000_0402;
      #1;
      if (c == 4) begin
        total++; if (imem_if.imem_req_valid_o !== 1'b1 || imem_if.imem_addr_o !== 32'h400) begin bad++; $display("FAIL b2b_target_req: got v=%b a=%h expected v=1 a=00000400", imem_if.imem_req_valid_o, imem_if.imem_addr_o); end
      end
      if (inst_valid && first_v < 0) begin first_v = c; fa = inst_addr; fd = inst; end
    end
    jump_en = 1'b0;
    total++; if (first_v !== 8 || fa !== 32'h400 || fd !== 32'hDEAD_0400) begin bad++; $display("FAIL b2b_first_valid: got c=%0d a=%h d=%h expected c=8 a=00000400 d=dead0400", first_v, fa, fd); end
  endtask

  task automatic test_wrap();
    lat = 1;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 0) begin
        total++; if (wrap_if.imem_req_valid_o !== 1'b1 || wrap_if.imem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first: got v=%b a=%h expected v=1 a=fffffffc", wrap_if.imem_req_valid_o, wrap_if.imem_addr_o); end
      end
      if (c == 1) begin
        total++; if (wrap_if.imem_req_valid_o !== 1'b1 || wrap_if.imem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_second: got v=%b a=%h expected v=1 a=00000000", wrap_if.imem_req_valid_o, wrap_if.imem_addr_o); end
        total++; if (wr_inst_valid !== 1'b0 || wr_inst !== 32'h0000_0013 || wr_inst_addr !== 32'h0) begin bad++; $display("FAIL wrap_idle_out: got v=%b d=%h a=%h expected v=0 d=00000013 a=0", wr_inst_valid, wr_inst, wr_inst_addr); end
      end
      if (c == 2) begin
        total++; if (wrap_if.imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL wrap_credit_limit: got %b expected 0", wrap_if.imem_req_valid_o); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; jump_en = 1'b0; jump_addr = 32'h0; hold = 1'b0;
    imem_if.imem_req_ready_i = 1'b1;
    test_reset();
    test_stream();
    test_hold();
    test_ready_stall();
    test_jump_inflight();
    test_jump_collide();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
